// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, bit-period computation and the
// receiver/transmitter FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta   <= RESET_VAL;
      o_sync <= RESET_VAL;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a down-counting bit timer, byte
// delivered on a valid/ready handshake with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq_hz = 100000000,
  parameter int baud_rate   = 115200
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(clk_freq_hz, baud_rate);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [2:0]           bit_idx, idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 tick;
  logic                 byte_done;
  logic                 frame_err_set;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_async(i_uart_rx),
    .o_sync (rx_s)
  );

  assign tick = (cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= idx_next;
      shreg   <= shreg_next;
    end
  end

  // The timer free-runs down to zero and parks there; each state reloads it
  // for the next sampling point.
  always_comb begin
    state_next    = state;
    cnt_next      = tick ? cnt : cnt - CNT_W'(1);
    idx_next      = bit_idx;
    shreg_next    = shreg;
    byte_done     = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_next   = FULL_LOAD;
            idx_next   = '0;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_next   = FULL_LOAD;
          idx_next   = bit_idx + 3'd1;
          if (bit_idx == LAST_IDX) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_next    = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A completing byte may replace the held one only if that one leaves now.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_err_set;
      o_overrun   <= 1'b0;
      if (byte_done) begin
        if (!o_valid || i_ready) begin
          o_data  <= shreg;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
